// File: rtl/hazard_control.sv
// Hazard controller for the 5-stage MIPS pipeline: operand forwarding, load-use/branch/mult-div
// stall and flush generation, mult/div occupancy tracking and a saturating stall-cycle counter.
module hazard_control #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             BranchD,
  input  logic             MdUseD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       writeRegE,
  input  logic             RegWriteE,
  input  logic             MemToRegE,
  input  logic             MdStartE,
  input  logic [4:0]       writeRegM,
  input  logic             RegWriteM,
  input  logic             MemToRegM,
  input  logic [4:0]       writeRegW,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             MdBusy,
  output logic             MdDone,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {S_IDLE, S_BUSY} md_state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(MD_LATENCY - 1);

  md_state_t        r_state;
  md_state_t        w_state_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic [CNT_W-1:0] r_stall_count;

  logic w_lwstall;
  logic w_brstall;
  logic w_mdstall;
  logic w_stall;
  logic w_e_hits_d;
  logic w_m_hits_d;

  // Forwarding selects; M-stage result has priority over W, and everything is masked in reset.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!rst) begin
      if (RsE != 5'd0 && RegWriteM && RsE == writeRegM)
        ForwardAE = 2'b10;
      else if (RsE != 5'd0 && RegWriteW && RsE == writeRegW)
        ForwardAE = 2'b01;
      if (RtE != 5'd0 && RegWriteM && RtE == writeRegM)
        ForwardBE = 2'b10;
      else if (RtE != 5'd0 && RegWriteW && RtE == writeRegW)
        ForwardBE = 2'b01;
      ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == writeRegM);
      ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == writeRegM);
    end
  end

  assign w_e_hits_d = RegWriteE && (writeRegE != 5'd0) &&
                      (writeRegE == RsD || writeRegE == RtD);
  assign w_m_hits_d = MemToRegM && (writeRegM != 5'd0) &&
                      (writeRegM == RsD || writeRegM == RtD);

  assign w_lwstall = MemToRegE && (RtE != 5'd0) && (RtE == RsD || RtE == RtD);
  assign w_brstall = BranchD && (w_e_hits_d || w_m_hits_d);
  // An op finishing this cycle lets the waiting consumer proceed immediately.
  assign w_mdstall = MdUseD && MdBusy && !MdDone;
  assign w_stall   = w_lwstall || w_brstall || w_mdstall;

  assign StallF = !rst && w_stall;
  assign StallD = !rst && w_stall;
  assign FlushE = rst || w_stall;

  assign MdBusy = (r_state == S_BUSY) && !rst;
  assign MdDone = MdBusy && (r_cnt == 4'd1);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (MdStartE) begin
          w_state_next = S_BUSY;
          w_cnt_next   = LP_CNT_INIT;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd1) begin
          // A start on the final cycle chains straight into the next op.
          if (MdStartE) begin
            w_state_next = S_BUSY;
            w_cnt_next   = LP_CNT_INIT;
          end else begin
            w_state_next = S_IDLE;
            w_cnt_next   = 4'd0;
          end
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_count <= '0;
    else if (StallD && r_stall_count != {CNT_W{1'b1}})
      r_stall_count <= r_stall_count + 1'b1;
  end

  assign StallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control: each cycle's expected outputs are queued when the inputs
// are driven and compared at the following falling edge.
module tb_hazard_control;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] RsD, RtD, RsE, RtE, writeRegE, writeRegM, writeRegW;
  logic BranchD, MdUseD, RegWriteE, MemToRegE, MdStartE;
  logic RegWriteM, MemToRegM, RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy, MdDone;
  logic [CNT_W-1:0] StallCount;

  hazard_control #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .MdUseD(MdUseD),
    .RsE(RsE), .RtE(RtE), .writeRegE(writeRegE), .RegWriteE(RegWriteE),
    .MemToRegE(MemToRegE), .MdStartE(MdStartE),
    .writeRegM(writeRegM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
    .writeRegW(writeRegW), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .MdBusy(MdBusy), .MdDone(MdDone), .StallCount(StallCount)
  );

  typedef struct {
    string       tag;
    logic [14:0] exp;
  } sb_t;

  sb_t        sb_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_cnt;

  wire [14:0] w_obs = {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE,
                       MdBusy, MdDone, StallCount};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $display("ok   %s observed=%h", tag, obs);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, 32'(w_obs), 32'(e.exp));
    end
  end

  task automatic clear_inputs();
    RsD = 0; RtD = 0; BranchD = 0; MdUseD = 0;
    RsE = 0; RtE = 0; writeRegE = 0; RegWriteE = 0; MemToRegE = 0; MdStartE = 0;
    writeRegM = 0; RegWriteM = 0; MemToRegM = 0; writeRegW = 0; RegWriteW = 0;
  endtask

  // Queue the expected outputs for the current inputs, then advance one clock.
  task automatic tick(input string tag, input logic [1:0] fae, input logic [1:0] fbe,
                      input logic fad, input logic fbd, input logic stall,
                      input logic busy, input logic done);
    sb_t e;
    e.tag = tag;
    e.exp = {fae, fbe, fad, fbd, stall, stall, (stall | rst), busy, done, exp_cnt};
    sb_q.push_back(e);
    @(posedge clk);
    if (rst) exp_cnt = 4'd0;
    else if (stall && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    exp_cnt = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset masks forwarding and stalls even with hazards on the inputs.
    RsE = 3; RegWriteM = 1; writeRegM = 3; MemToRegE = 1; RtE = 5; RsD = 5; MdStartE = 1;
    tick("rst_mask", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    rst = 1'b0;
    clear_inputs();
    tick("idle", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Forwarding priority and register 0.
    RegWriteM = 1; writeRegM = 3; RegWriteW = 1; writeRegW = 3; RsE = 3; RtE = 3; RsD = 3;
    tick("fwd_mpri", 2'b10, 2'b10, 1, 0, 0, 0, 0);
    RegWriteM = 0; writeRegW = 4; RtE = 4;
    tick("fwd_w", 2'b00, 2'b01, 0, 0, 0, 0, 0);
    RegWriteM = 1; writeRegM = 0; RegWriteW = 1; writeRegW = 0; RsE = 0; RtE = 0; RsD = 0;
    tick("fwd_r0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    clear_inputs();
    RtD = 9; RegWriteM = 1; writeRegM = 9;
    tick("fwd_bd", 2'b00, 2'b00, 0, 1, 0, 0, 0);

    // Load-use: one stall, then the load moves to M and W.
    clear_inputs();
    MemToRegE = 1; RegWriteE = 1; RtE = 5; writeRegE = 5; RsD = 5;
    tick("lw_stall", 2'b00, 2'b00, 0, 0, 1, 0, 0);
    clear_inputs();
    RsD = 5; RegWriteM = 1; MemToRegM = 1; writeRegM = 5;
    tick("lw_in_m", 2'b00, 2'b00, 1, 0, 0, 0, 0);
    clear_inputs();
    RsE = 5; RegWriteW = 1; writeRegW = 5;
    tick("lw_use_e", 2'b01, 2'b00, 0, 0, 0, 0, 0);
    clear_inputs();
    MemToRegE = 1; RtE = 0; RsD = 0;
    tick("lw_r0", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Branch operand hazards.
    clear_inputs();
    BranchD = 1; RsD = 7; RegWriteE = 1; writeRegE = 7;
    tick("br_e", 2'b00, 2'b00, 0, 0, 1, 0, 0);
    RegWriteE = 0; writeRegE = 0; RegWriteM = 1; writeRegM = 7;
    tick("br_m_alu", 2'b00, 2'b00, 1, 0, 0, 0, 0);
    MemToRegM = 1;
    tick("br_m_lw", 2'b00, 2'b00, 1, 0, 1, 0, 0);
    clear_inputs();
    BranchD = 1; RsD = 1; RtD = 7; RegWriteE = 1; writeRegE = 7;
    tick("br_rt", 2'b00, 2'b00, 0, 0, 1, 0, 0);
    clear_inputs();
    BranchD = 1; RegWriteE = 1; writeRegE = 0;
    tick("br_r0", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Single mult/div op with a waiting consumer.
    clear_inputs();
    MdStartE = 1;
    tick("md_c0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    MdStartE = 0; MdUseD = 1;
    tick("md_c1", 2'b00, 2'b00, 0, 0, 1, 1, 0);
    tick("md_c2", 2'b00, 2'b00, 0, 0, 1, 1, 0);
    tick("md_c3", 2'b00, 2'b00, 0, 0, 0, 1, 1);
    tick("md_c4", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Back-to-back ops: no idle gap.
    clear_inputs();
    MdStartE = 1;
    tick("b2b_c0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    MdStartE = 0;
    tick("b2b_c1", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    tick("b2b_c2", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    MdStartE = 1;
    tick("b2b_c3", 2'b00, 2'b00, 0, 0, 0, 1, 1);
    MdStartE = 0;
    tick("b2b_c4", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    tick("b2b_c5", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    tick("b2b_c6", 2'b00, 2'b00, 0, 0, 0, 1, 1);
    tick("b2b_c7", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Reset during an op aborts it without a done pulse.
    MdStartE = 1;
    tick("mdrst_c0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    MdStartE = 0;
    tick("mdrst_c1", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    rst = 1'b1;
    tick("mdrst_c2", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick("mdrst_c3", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    tick("mdrst_c4", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Counter saturation under a held load-use stall.
    clear_inputs();
    MemToRegE = 1; RtE = 5; RsD = 5;
    for (int i = 0; i < 20; i++) tick($sformatf("sat_%0d", i), 2'b00, 2'b00, 0, 0, 1, 0, 0);
    clear_inputs();
    tick("sat_hold", 2'b00, 2'b00, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
